// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - states, AXI constants and helpers shared by the DRAM request arbiter
package dram_arb_pkg;

   localparam int N_REQ = 2;

   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, WRESP, RDATA} state_t;

   function automatic logic [N_REQ-1:0] onehot(input logic idx);
      logic [N_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant select, purely combinational
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       any_req
);

   assign any_req = |req;
   // A lone requester wins outright; a tie goes to whoever was not served last.
   assign grant   = (req == 2'b11) ? ~last_grant : req[1];

endmodule

// File: rtl/dram_req_arbiter.sv
// rtl/dram_req_arbiter.sv - two-requester round-robin arbiter driving single AXI bursts to the DRAM wrapper
module dram_req_arbiter
   import dram_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 4,
   parameter int ID_W   = 8
) (
   input  logic                             ACLK,
   input  logic                             ARESETn,
   input  logic [N_REQ-1:0]                 m_req_valid,
   input  logic [N_REQ-1:0]                 m_req_write,
   input  logic [N_REQ-1:0][ADDR_W-1:0]     m_req_addr,
   input  logic [N_REQ-1:0][LEN_W-1:0]      m_req_len,
   output logic [N_REQ-1:0]                 m_req_ready,
   input  logic [N_REQ-1:0][DATA_W-1:0]     m_wdata,
   input  logic [N_REQ-1:0][DATA_W/8-1:0]   m_wstrb,
   input  logic [N_REQ-1:0]                 m_wvalid,
   output logic [N_REQ-1:0]                 m_wready,
   output logic [DATA_W-1:0]                m_rdata,
   output logic [N_REQ-1:0]                 m_rvalid,
   output logic                             m_rlast,
   output logic [N_REQ-1:0]                 m_done,
   output logic [1:0]                       m_resp,
   output logic [ID_W-1:0]                  AWID_M,
   output logic [ADDR_W-1:0]                AWADDR_M,
   output logic [LEN_W-1:0]                 AWLEN_M,
   output logic [2:0]                       AWSIZE_M,
   output logic [1:0]                       AWBURST_M,
   output logic                             AWVALID_M,
   input  logic                             AWREADY_M,
   output logic [ID_W-1:0]                  ARID_M,
   output logic [ADDR_W-1:0]                ARADDR_M,
   output logic [LEN_W-1:0]                 ARLEN_M,
   output logic [2:0]                       ARSIZE_M,
   output logic [1:0]                       ARBURST_M,
   output logic                             ARVALID_M,
   input  logic                             ARREADY_M,
   output logic [DATA_W-1:0]                WDATA_M,
   output logic [DATA_W/8-1:0]              WSTRB_M,
   output logic                             WLAST_M,
   output logic                             WVALID_M,
   input  logic                             WREADY_M,
   input  logic [ID_W-1:0]                  BID_M,
   input  logic [1:0]                       BRESP_M,
   input  logic                             BVALID_M,
   output logic                             BREADY_M,
   input  logic [ID_W-1:0]                  RID_M,
   input  logic [DATA_W-1:0]                RDATA_M,
   input  logic [1:0]                       RRESP_M,
   input  logic                             RLAST_M,
   input  logic                             RVALID_M,
   output logic                             RREADY_M
);

   state_t              state;
   logic                last_grant;
   logic                gnt;
   logic                write_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    beat_cnt;
   logic                awvalid;
   logic                arvalid;
   logic                rd_err;
   logic [N_REQ-1:0]    done;
   logic [1:0]          resp;
   logic [ID_W-1:0]     id_q;
   logic                arb_grant;
   logic                any_req;

   rr_arb2 u_rr_arb2 (
      .req        (m_req_valid),
      .last_grant (last_grant),
      .grant      (arb_grant),
      .any_req    (any_req)
   );

   assign id_q = {{(ID_W-1){1'b0}}, gnt};

   always_ff @(posedge ACLK) begin
      if (!ARESETn) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         gnt        <= 1'b0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         beat_cnt   <= '0;
         awvalid    <= 1'b0;
         arvalid    <= 1'b0;
         rd_err     <= 1'b0;
         done       <= '0;
         resp       <= AXI_RESP_OKAY;
      end else begin
         done <= '0;
         case (state)
            IDLE: begin
               beat_cnt <= '0;
               rd_err   <= 1'b0;
               if (any_req) begin
                  gnt     <= arb_grant;
                  write_q <= m_req_write[arb_grant];
                  addr_q  <= m_req_addr[arb_grant];
                  len_q   <= m_req_len[arb_grant];
                  awvalid <= m_req_write[arb_grant];
                  arvalid <= ~m_req_write[arb_grant];
                  state   <= ADDR;
               end
            end
            ADDR: begin
               if ((awvalid && AWREADY_M) || (arvalid && ARREADY_M)) begin
                  awvalid <= 1'b0;
                  arvalid <= 1'b0;
                  state   <= write_q ? WDATA : RDATA;
               end
            end
            WDATA: begin
               if (WVALID_M && WREADY_M) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (beat_cnt == len_q)
                     state <= WRESP;
               end
            end
            WRESP: begin
               if (BVALID_M) begin
                  done[gnt]  <= 1'b1;
                  resp       <= (BID_M != id_q) ? AXI_RESP_SLVERR : BRESP_M;
                  last_grant <= gnt;
                  state      <= IDLE;
               end
            end
            RDATA: begin
               if (RVALID_M) begin
                  beat_cnt <= beat_cnt + 1'b1;
                  if (RID_M != id_q)
                     rd_err <= 1'b1;
                  // A wrong ID on any beat, or RLAST at the wrong count, poisons the whole burst.
                  if (RLAST_M) begin
                     done[gnt]  <= 1'b1;
                     resp       <= (rd_err || (RID_M != id_q) || (beat_cnt != len_q))
                                   ? AXI_RESP_SLVERR : RRESP_M;
                     last_grant <= gnt;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign m_req_ready = (ARESETn && state == IDLE && any_req) ? onehot(arb_grant) : '0;

   assign AWID_M    = id_q;
   assign AWADDR_M  = addr_q;
   assign AWLEN_M   = len_q;
   assign AWSIZE_M  = AXI_SIZE_4B;
   assign AWBURST_M = AXI_BURST_INCR;
   assign AWVALID_M = awvalid;
   assign ARID_M    = id_q;
   assign ARADDR_M  = addr_q;
   assign ARLEN_M   = len_q;
   assign ARSIZE_M  = AXI_SIZE_4B;
   assign ARBURST_M = AXI_BURST_INCR;
   assign ARVALID_M = arvalid;

   assign WDATA_M   = m_wdata[gnt];
   assign WSTRB_M   = m_wstrb[gnt];
   assign WVALID_M  = (state == WDATA) && m_wvalid[gnt];
   assign WLAST_M   = (state == WDATA) && (beat_cnt == len_q);
   assign m_wready  = (state == WDATA && WREADY_M) ? onehot(gnt) : '0;

   assign BREADY_M  = (state == WRESP);
   assign RREADY_M  = (state == RDATA);
   assign m_rdata   = RDATA_M;
   assign m_rlast   = (state == RDATA) && RLAST_M;
   assign m_rvalid  = (state == RDATA && RVALID_M) ? onehot(gnt) : '0;

   assign m_done    = done;
   assign m_resp    = resp;

endmodule

// File: tb/tb_dram_req_arbiter.sv
// tb/tb_dram_req_arbiter.sv - directed self-checking bench for dram_req_arbiter
module tb_dram_req_arbiter;

   logic             ACLK;
   logic             ARESETn;
   logic [1:0]       m_req_valid;
   logic [1:0]       m_req_write;
   logic [1:0][31:0] m_req_addr;
   logic [1:0][3:0]  m_req_len;
   logic [1:0]       m_req_ready;
   logic [1:0][31:0] m_wdata;
   logic [1:0][3:0]  m_wstrb;
   logic [1:0]       m_wvalid;
   logic [1:0]       m_wready;
   logic [31:0]      m_rdata;
   logic [1:0]       m_rvalid;
   logic             m_rlast;
   logic [1:0]       m_done;
   logic [1:0]       m_resp;
   logic [7:0]       AWID_M, ARID_M;
   logic [31:0]      AWADDR_M, ARADDR_M;
   logic [3:0]       AWLEN_M, ARLEN_M;
   logic [2:0]       AWSIZE_M, ARSIZE_M;
   logic [1:0]       AWBURST_M, ARBURST_M;
   logic             AWVALID_M, AWREADY_M, ARVALID_M, ARREADY_M;
   logic [31:0]      WDATA_M;
   logic [3:0]       WSTRB_M;
   logic             WLAST_M, WVALID_M, WREADY_M;
   logic [7:0]       BID_M;
   logic [1:0]       BRESP_M;
   logic             BVALID_M, BREADY_M;
   logic [7:0]       RID_M;
   logic [31:0]      RDATA_M;
   logic [1:0]       RRESP_M;
   logic             RLAST_M, RVALID_M, RREADY_M;

   int n_vec  = 0;
   int n_miss = 0;

   dram_req_arbiter dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .m_req_valid(m_req_valid), .m_req_write(m_req_write), .m_req_addr(m_req_addr),
      .m_req_len(m_req_len), .m_req_ready(m_req_ready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rlast(m_rlast),
      .m_done(m_done), .m_resp(m_resp),
      .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
      .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
      .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
      .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
      .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
      .WREADY_M(WREADY_M),
      .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M),
      .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
      .RVALID_M(RVALID_M), .RREADY_M(RREADY_M)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] oh(input int r);
      return (r == 0) ? 2'b01 : 2'b10;
   endfunction

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      expect_eq({tag, "_awvalid"}, AWVALID_M, 1'b0);
      expect_eq({tag, "_arvalid"}, ARVALID_M, 1'b0);
      expect_eq({tag, "_wvalid"}, WVALID_M, 1'b0);
      expect_eq({tag, "_bready"}, BREADY_M, 1'b0);
      expect_eq({tag, "_rready"}, RREADY_M, 1'b0);
      expect_eq({tag, "_req_ready"}, m_req_ready, 2'b00);
      expect_eq({tag, "_wready"}, m_wready, 2'b00);
      expect_eq({tag, "_rvalid"}, m_rvalid, 2'b00);
      expect_eq({tag, "_done"}, m_done, 2'b00);
   endtask

   task automatic apply_reset();
      ARESETn = 1'b0;
      tick();
      tick();
      check_quiet("rst");
      expect_eq("rst_resp", m_resp, 2'b00);
      ARESETn = 1'b1;
   endtask

   task automatic post_req(input int r, input logic wr, input logic [31:0] a, input logic [3:0] l);
      m_req_valid[r] = 1'b1;
      m_req_write[r] = wr;
      m_req_addr[r]  = a;
      m_req_len[r]   = l;
   endtask

   task automatic run_read(input int r, input logic [31:0] a, input logic [3:0] l, input int nbeats,
                           input logic [7:0] rid, input int ar_stall, input logic [1:0] exp_resp);
      logic [31:0] d;
      post_req(r, 1'b0, a, l);
      #1;
      expect_eq("rd_grant", m_req_ready, oh(r));
      tick();
      m_req_valid[r] = 1'b0;
      for (int i = 0; i <= ar_stall; i++) begin
         ARREADY_M = (i == ar_stall);
         #1;
         expect_eq("rd_arvalid", ARVALID_M, 1'b1);
         expect_eq("rd_awvalid", AWVALID_M, 1'b0);
         expect_eq("rd_araddr", ARADDR_M, a);
         expect_eq("rd_arlen", ARLEN_M, l);
         expect_eq("rd_arid", ARID_M, r);
         expect_eq("rd_arsize", ARSIZE_M, 3'b010);
         expect_eq("rd_arburst", ARBURST_M, 2'b01);
         expect_eq("rd_nogrant", m_req_ready, 2'b00);
         tick();
      end
      ARREADY_M = 1'b0;
      for (int i = 0; i < nbeats; i++) begin
         d = a ^ (32'h0101_0101 * (i + 1));
         RVALID_M = 1'b1;
         RDATA_M  = d;
         RID_M    = rid;
         RRESP_M  = 2'b00;
         RLAST_M  = (i == nbeats - 1);
         #1;
         expect_eq("rd_rready", RREADY_M, 1'b1);
         expect_eq("rd_rvalid", m_rvalid, oh(r));
         expect_eq("rd_rdata", m_rdata, d);
         expect_eq("rd_rlast", m_rlast, (i == nbeats - 1));
         expect_eq("rd_nogrant", m_req_ready, 2'b00);
         tick();
      end
      RVALID_M = 1'b0;
      RLAST_M  = 1'b0;
      #1;
      expect_eq("rd_done", m_done, oh(r));
      expect_eq("rd_resp", m_resp, exp_resp);
   endtask

   task automatic run_write(input int r, input logic [31:0] a, input logic [3:0] l, input logic [7:0] bid,
                            input int w_stall, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [3:0] s, input logic [1:0] exp_resp);
      logic [31:0] d;
      post_req(r, 1'b1, a, l);
      #1;
      expect_eq("wr_grant", m_req_ready, oh(r));
      tick();
      m_req_valid[r] = 1'b0;
      AWREADY_M = 1'b1;
      #1;
      expect_eq("wr_awvalid", AWVALID_M, 1'b1);
      expect_eq("wr_arvalid", ARVALID_M, 1'b0);
      expect_eq("wr_awaddr", AWADDR_M, a);
      expect_eq("wr_awlen", AWLEN_M, l);
      expect_eq("wr_awid", AWID_M, r);
      tick();
      AWREADY_M   = 1'b0;
      m_wvalid[r] = 1'b1;
      m_wdata[r]  = d0;
      m_wstrb[r]  = s;
      repeat (w_stall) begin
         WREADY_M = 1'b0;
         #1;
         expect_eq("wr_stall_wvalid", WVALID_M, 1'b1);
         expect_eq("wr_stall_wdata", WDATA_M, d0);
         expect_eq("wr_stall_wlast", WLAST_M, (l == 4'd0));
         expect_eq("wr_stall_wready", m_wready, 2'b00);
         tick();
      end
      for (int i = 0; i <= int'(l); i++) begin
         d = (i == 0) ? d0 : (i == 1) ? d1 : d1 + i;
         m_wdata[r] = d;
         WREADY_M   = 1'b1;
         #1;
         expect_eq("wr_wvalid", WVALID_M, 1'b1);
         expect_eq("wr_wdata", WDATA_M, d);
         expect_eq("wr_wstrb", WSTRB_M, s);
         expect_eq("wr_wlast", WLAST_M, (i == int'(l)));
         expect_eq("wr_wready", m_wready, oh(r));
         tick();
      end
      m_wvalid[r] = 1'b0;
      WREADY_M    = 1'b0;
      #1;
      expect_eq("wr_bready", BREADY_M, 1'b1);
      expect_eq("wr_wvalid_off", WVALID_M, 1'b0);
      BVALID_M = 1'b1;
      BID_M    = bid;
      BRESP_M  = 2'b00;
      tick();
      BVALID_M = 1'b0;
      #1;
      expect_eq("wr_done", m_done, oh(r));
      expect_eq("wr_resp", m_resp, exp_resp);
   endtask

   initial begin
      ARESETn = 1'b0;
      m_req_valid = '0; m_req_write = '0; m_req_addr = '0; m_req_len = '0;
      m_wdata = '0; m_wstrb = '0; m_wvalid = '0;
      AWREADY_M = 1'b0; ARREADY_M = 1'b0; WREADY_M = 1'b0;
      BID_M = '0; BRESP_M = '0; BVALID_M = 1'b0;
      RID_M = '0; RDATA_M = '0; RRESP_M = '0; RLAST_M = 1'b0; RVALID_M = 1'b0;
      tick();
      apply_reset();

      run_read(0, 32'h0000_1000, 4'd3, 4, 8'h00, 0, 2'b00);
      tick();
      expect_eq("done_pulse", m_done, 2'b00);

      // strict alternation from reset; requester 0 first, 1 waits through a 6-cycle AR stall
      apply_reset();
      post_req(1, 1'b0, 32'h0000_3000, 4'd0);
      run_read(0, 32'h0000_4000, 4'd1, 2, 8'h00, 6, 2'b00);
      post_req(0, 1'b0, 32'h0000_4100, 4'd0);
      run_read(1, 32'h0000_3000, 4'd0, 1, 8'h01, 0, 2'b00);
      post_req(1, 1'b0, 32'h0000_3100, 4'd0);
      run_read(0, 32'h0000_4100, 4'd0, 1, 8'h00, 0, 2'b00);
      run_read(1, 32'h0000_3100, 4'd0, 1, 8'h01, 0, 2'b00);

      run_write(1, 32'h0000_2000, 4'd1, 8'h01, 3, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'hF, 2'b00);
      run_write(0, 32'h0000_5000, 4'd0, 8'h05, 0, 32'h1234_5678, 32'h0, 4'h3, 2'b10);
      run_read(1, 32'h0000_8000, 4'd3, 2, 8'h01, 0, 2'b10);
      run_read(0, 32'h0000_9000, 4'd1, 2, 8'h07, 0, 2'b10);

      // reset during beat 2 of a len=7 read
      post_req(0, 1'b0, 32'h0000_6000, 4'd7);
      tick();
      m_req_valid[0] = 1'b0;
      ARREADY_M = 1'b1;
      tick();
      ARREADY_M = 1'b0;
      for (int i = 0; i < 2; i++) begin
         RVALID_M = 1'b1;
         RDATA_M  = 32'h6000 + i;
         RID_M    = 8'h00;
         tick();
      end
      ARESETn = 1'b0;
      tick();
      check_quiet("midrst");
      RVALID_M = 1'b0;
      ARESETn  = 1'b1;
      tick();
      run_read(1, 32'h0000_7000, 4'd2, 3, 8'h01, 0, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/dram_req_arbiter.md
Name: dram_req_arbiter

Overview:
- Two-requester arbiter and AXI sequencer in front of the DRAM slave wrapper.
- Requesters are, for example, the instruction-side and data-side cache refill/writeback engines.
- Each requester issues a simple burst request (addr, len, read/write). The block grants one requester round-robin, then drives one complete AXI read or write burst on its master port to the DRAM wrapper.
- It forwards data beats between the granted requester and AXI and reports completion.
- Only one transaction is outstanding at a time.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (STRB = DATA_W/8)
- LEN_W, 4, AXI burst length field width (beats = len+1)
- ID_W, 8, AXI ID width

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  reset, synchronous, active-low
- m_req_valid  in  [1:0]  per-requester request valid
- m_req_write  in  [1:0]  1 = write burst, 0 = read burst
- m_req_addr  in  [1:0][ADDR_W-1:0]  burst start address, word aligned
- m_req_len  in  [1:0][LEN_W-1:0]  beats minus one
- m_req_ready  out  [1:0]  request accepted, one-hot or zero
- m_wdata / m_wstrb  in  [1:0][DATA_W-1:0] / [1:0][DATA_W/8-1:0]  write beat data / byte strobes
- m_wvalid  in  [1:0]  write beat valid
- m_wready  out  [1:0]  write beat accepted
- m_rdata  out  DATA_W  read data, shared
- m_rvalid  out  [1:0]  read beat valid to the granted requester
- m_rlast  out  1  last read beat
- m_done  out  [1:0]  one-cycle completion pulse
- m_resp  out  2  response of the finished burst, valid with m_done
- AWID_M/ARID_M  out  ID_W  {0, grant index}
- AWADDR_M/ARADDR_M  out  ADDR_W  latched address
- AWLEN_M/ARLEN_M  out  LEN_W  latched length
- AWSIZE_M/ARSIZE_M  out  3  fixed 3'b010
- AWBURST_M/ARBURST_M  out  2  fixed INCR 2'b01
- AWVALID_M, ARVALID_M  out  1  address valid
- AWREADY_M, ARREADY_M  in  1  address ready
- WDATA_M, WSTRB_M, WLAST_M, WVALID_M  out  DATA_W, DATA_W/8, 1, 1  write channel
- WREADY_M  in  1  write ready
- BID_M, BRESP_M, BVALID_M  in  ID_W, 2, 1  write response
- BREADY_M  out  1  write response ready
- RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M  in  ID_W, DATA_W, 2, 1, 1  read channel
- RREADY_M  out  1  read ready

Behaviour:
- Reset, sampled at the ACLK edge with ARESETn low:
  - state=IDLE, last_grant=1 (so requester 0 wins first), beat_cnt=0.
  - All *VALID_M, BREADY_M, RREADY_M, m_req_ready, m_wready, m_rvalid and m_done are 0.
  - m_resp=0.
- Reset mid-burst aborts the burst and the block returns to IDLE. The DRAM wrapper shares this reset.
- IDLE:
  - If any m_req_valid is set, grant g is chosen combinationally in the same cycle.
  - Single requester: grant it. Both requesters: grant ~last_grant.
  - m_req_ready[g]=1 in that cycle; addr/len/write/g are latched.
  - Next state: ADDR.
  - At least one IDLE cycle separates consecutive bursts.
- ADDR:
  - Assert AWVALID_M (write) or ARVALID_M (read) from the latched registers. Never assert both.
  - Hold VALID and all fields stable until READY.
  - Handshake moves to WDATA (write) or RDATA (read).
- WDATA:
  - WVALID_M=m_wvalid[g]; m_wready[g]=WREADY_M. WDATA_M/WSTRB_M are muxed combinationally from g.
  - WLAST_M=(beat_cnt==len). beat_cnt increments on each W handshake.
  - Last-beat handshake moves to WRESP.
- WRESP:
  - BREADY_M=1. On BVALID_M: m_done[g]=1 for one cycle, m_resp=BRESP_M, last_grant=g, go to IDLE.
- RDATA:
  - RREADY_M=1; requesters must always accept read beats.
  - m_rvalid[g]=RVALID_M; m_rdata=RDATA_M; m_rlast=RLAST_M.
  - On RVALID_M&RLAST_M: m_done[g] pulse, last_grant=g, go to IDLE.
  - beat_cnt counts beats. RLAST_M arriving with beat_cnt!=len still ends the burst with m_resp=SLVERR.
- Response ID check: if BID_M/RID_M != latched ID, m_resp is forced to 2'b10 (SLVERR). The burst still completes.
- Non-granted requester: its m_req_ready, m_wready, m_rvalid and m_done stay 0 for the whole burst.
- Withdrawing m_req_valid before grant is legal; no grant results.
- beat_cnt is LEN_W bits wide, cleared in IDLE. len=0 gives a single beat with WLAST_M on the first beat.

Decomposition:
- Package dram_arb_pkg:
  - state enum {IDLE, ADDR, WDATA, WRESP, RDATA}
  - AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10
  - N_REQ=2
- One sub-module, rr_arb2: inputs req[1:0] and last_grant; outputs grant index and any_req. Purely combinational.

Test Plan:
- Req0 read addr=0x0000_1000 len=3, DRAM returns 4 beats with RID=0 → ARADDR_M=0x1000, ARLEN_M=3, ARID_M=0, m_rvalid[0] 4 times, m_rlast on beat 4, m_done[0] pulse with m_resp=00.
- Both requesters valid in the same cycle, from reset → requester 0 granted first. On re-request, requester 1 is granted next, then 0 again (strict alternation over 4 bursts).
- Req1 write addr=0x0000_2000 len=1, data 0xDEADBEEF/0xCAFEF00D with strobe 4'hF; WREADY_M stalls 3 cycles → AWID_M=1; WLAST_M only on beat 2; data unchanged through the stall; m_done[1] after BVALID_M.
- ARREADY_M held low 6 cycles → ARVALID_M and ARADDR_M stay stable; no m_req_ready pulse for requester 1 while it waits.
- BID_M=5 returned for a grant-0 write → m_done[0] with m_resp=2'b10.
- ARESETn low during beat 2 of a len=7 read → next cycle state IDLE and all VALID/ready outputs 0; a fresh request afterwards completes normally.
